// File: rtl/dram_ctrl_pkg.sv
// Shared types for the DRAM port controller: controller FSM states and arbiter
// request indices.
package dram_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    localparam int unsigned ARB_WR = 0;
    localparam int unsigned ARB_RD = 1;

endpackage

// File: rtl/dram_rr_arb2.sv
// Two-way round-robin arbiter: one-hot combinational grant, and a last-grant
// pointer that is updated on every grant.
module dram_rr_arb2
    import dram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // The request that was not granted last wins a contested cycle.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (gnt[ARB_WR]) begin
            last_d = 1'b0;
        end else if (gnt[ARB_RD]) begin
            last_d = 1'b1;
        end else begin
            last_d = last_q;
        end
    end

    // The pointer resets to read, so the first contested cycle grants the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dram_port_ctrl.sv
// Write/read port controller for an external single-port distributed RAM.
// The clear-on-reset sweep is built only when DRAM_PORT_CTRL_INIT_CLEAR_EN is defined.
module dram_port_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int WIDTH = 605,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_valid,
    output logic                     rd_ready,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [$clog2(DEPTH)-1:0] ram_addr,
    output logic                     ram_we,
    output logic [WIDTH-1:0]         ram_din,
    input  logic [WIDTH-1:0]         ram_dout,
    output logic                     init_busy
);

    localparam int AW = $clog2(DEPTH);

    logic          run_s;
    logic [AW-1:0] clr_addr_s;

`ifdef DRAM_PORT_CTRL_INIT_CLEAR_EN
    ctrl_state_e   state_q;
    ctrl_state_e   state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;
    logic          init_busy_q;
    logic          init_busy_d;

    // Clear sweep: one entry per cycle, leaving for RUN once the last entry is written.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_busy_d = init_busy_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d     = ST_RUN;
                    cnt_d       = {AW{1'b0}};
                    init_busy_d = 1'b0;
                end else begin
                    cnt_d       = cnt_q + AW'(1);
                    init_busy_d = 1'b1;
                end
            end
            ST_RUN: begin
                init_busy_d = 1'b0;
            end
            default: begin
                state_d     = ST_INIT;
                cnt_d       = {AW{1'b0}};
                init_busy_d = 1'b1;
            end
        endcase
    end

    // Controller FSM state, sweep counter and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= {AW{1'b0}};
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
        end
    end

    assign run_s      = (state_q == ST_RUN);
    assign clr_addr_s = cnt_q;
    assign init_busy  = init_busy_q;
`else
    assign run_s      = 1'b1;
    assign clr_addr_s = {AW{1'b0}};
    assign init_busy  = 1'b0;
`endif

    logic             rsp_valid_q;
    logic             rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q;
    logic [WIDTH-1:0] rsp_data_d;
    logic             rd_free_s;
    logic [1:0]       req_s;
    logic [1:0]       gnt_s;
    logic             wr_hs_s;
    logic             rd_hs_s;

    // A read may enter only when the response slot is empty or drains this cycle.
    assign rd_free_s = !rsp_valid_q || rsp_ready;

    assign req_s[ARB_WR] = run_s && wr_valid;
    assign req_s[ARB_RD] = run_s && rd_valid && rd_free_s;

    dram_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_s),
        .gnt   (gnt_s)
    );

    // A port is ready unless the other port holds the grant this cycle.
    assign wr_ready = run_s && !gnt_s[ARB_RD];
    assign rd_ready = run_s && rd_free_s && !gnt_s[ARB_WR];
    assign wr_hs_s  = gnt_s[ARB_WR];
    assign rd_hs_s  = gnt_s[ARB_RD];

    // RAM port mux: clear sweep, then write handshake, otherwise read address.
    always_comb begin
        ram_addr = rd_addr;
        ram_we   = 1'b0;
        ram_din  = {WIDTH{1'b0}};
        if (!run_s) begin
            ram_addr = clr_addr_s;
            ram_we   = 1'b1;
        end else if (wr_hs_s) begin
            ram_addr = wr_addr;
            ram_we   = 1'b1;
            ram_din  = wr_data;
        end else begin
            ram_addr = rd_addr;
            ram_we   = 1'b0;
        end
    end

    // Response slot: load on read handshake, hold until the consumer takes it.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (rd_hs_s) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = ram_dout;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Registered read response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {WIDTH{1'b0}};
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
